// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Brief    : Shared memory-bus definitions. Holds the access-width codes and
//             the arbiter FSM encoding. The UART DMA and the CPU ports use the
//             same definitions.
//  Revision : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef logic [1:0] mem_acc_t;

    localparam mem_acc_t MEM_ACC_8  = 2'b00;
    localparam mem_acc_t MEM_ACC_16 = 2'b01;
    localparam mem_acc_t MEM_ACC_32 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    // Round-robin successor of a grant index, wrapping n-1 -> 0.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Requester-side and memory-side bus bundle of the arbiter.
//             The "master" modport is the arbiter's view. The "slave" modport
//             is the view of the surrounding requesters and memory.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int M_WIDTH = 32,
    parameter int NUM_REQ = 3,
    parameter int GNT_W   = 2
) ();

    // requester side, port i occupies slice [i*W +: W]
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         req_we;
    logic [NUM_REQ*M_WIDTH-1:0] req_addr;
    logic [NUM_REQ*2-1:0]       req_width;
    logic [NUM_REQ*M_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]         req_ready;
    logic [M_WIDTH-1:0]         req_rdata;
    logic [GNT_W-1:0]           gnt_id;

    // downstream memory side
    logic                       mem_req;
    logic                       mem_we;
    logic [M_WIDTH-1:0]         mem_addr;
    mem_acc_t                   mem_width;
    logic [M_WIDTH-1:0]         mem_wdata;
    logic [M_WIDTH-1:0]         mem_rdata;
    logic                       mem_ready;

    modport master (
        input  req, req_we, req_addr, req_width, req_wdata, mem_rdata, mem_ready,
        output req_ready, req_rdata, gnt_id,
               mem_req, mem_we, mem_addr, mem_width, mem_wdata
    );

    modport slave (
        output req, req_we, req_addr, req_width, req_wdata, mem_rdata, mem_ready,
        input  req_ready, req_rdata, gnt_id,
               mem_req, mem_we, mem_addr, mem_width, mem_wdata
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_rr_picker
//  Brief    : Combinational round-robin picker. Finds the first request at or
//             above rr_ptr, wrapping past NUM_REQ-1 to 0. The request vector
//             is duplicated and masked, then priority-encoded, so the wrap
//             needs no separate second pass.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int GNT_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   rr_ptr,
    output logic               any,
    output logic [GNT_W-1:0]   gnt
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [2*NUM_REQ-1:0] w_mask;
    logic [2*NUM_REQ-1:0] w_masked;

    assign w_dbl    = {req, req};
    assign w_masked = w_dbl & w_mask;
    assign any      = |req;

    // Keep only positions at or above rr_ptr. The upper copy supplies the wrapped-around ports.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            w_mask[i] = (i >= int'(rr_ptr));
        end
    end

    // Lowest set masked bit wins. Its position modulo NUM_REQ is the port index.
    always_comb begin
        gnt = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                gnt = GNT_W'(i % NUM_REQ);
            end
        end
    end

endmodule : mem_port_arbiter_rr_picker
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one memory bus among NUM_REQ requesters. The grant is
//             round-robin and only one transaction is in flight at a time.
//             The grant and the winner's request are latched in IDLE. ACCESS
//             drives the downstream port from those latches until mem_ready.
//             DONE pulses the winner's ready. Read data stays held until the
//             next completion.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int M_WIDTH = 32,
    parameter int NUM_REQ = 3,
    parameter int GNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.master bus
);

    import mem_port_arbiter_pkg::*;

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [GNT_W-1:0]   r_rr_ptr;
    logic [GNT_W-1:0]   r_gnt;
    logic [GNT_W-1:0]   w_pick;
    logic               w_any;
    logic               w_grant;
    logic               w_capture;
    logic               w_mem_req;
    logic               w_ready_pulse;

    logic               r_we;
    logic [M_WIDTH-1:0] r_addr;
    mem_acc_t           r_width;
    logic [M_WIDTH-1:0] r_wdata;
    logic [M_WIDTH-1:0] r_rdata;

    mem_port_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_picker (
        .req    (bus.req),
        .rr_ptr (r_rr_ptr),
        .any    (w_any),
        .gnt    (w_pick)
    );

    // State register. Reset aborts any access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_next        = r_state;
        w_grant       = 1'b0;
        w_capture     = 1'b0;
        w_mem_req     = 1'b0;
        w_ready_pulse = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant = 1'b1;
                    w_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ready_pulse = 1'b1;
                w_next        = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the winning request and advance the pointer. Capture read data on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_width  <= MEM_ACC_8;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_gnt    <= w_pick;
                r_rr_ptr <= GNT_W'(rr_wrap(int'(w_pick), NUM_REQ));
                r_we     <= bus.req_we[w_pick];
                r_addr   <= bus.req_addr[w_pick*M_WIDTH +: M_WIDTH];
                r_width  <= bus.req_width[w_pick*2 +: 2];
                r_wdata  <= bus.req_wdata[w_pick*M_WIDTH +: M_WIDTH];
            end
            if (w_capture) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    // One-hot completion pulse, steered by the latched grant.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = w_ready_pulse && (r_gnt == GNT_W'(gi));
        end
    endgenerate

    assign bus.req_rdata = r_rdata;
    assign bus.gnt_id    = r_gnt;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_width = r_width;
    assign bus.mem_wdata = r_wdata;

endmodule : mem_port_arbiter
`default_nettype wire
